square_signal_meter: RTL and testbench

- Receive-side counterpart to the square-wave generator: measures an external square wave on one input pin.
- Outputs per-edge period and high time, frequency in Hz over a 1 s gate, a lock/active flag and the whole seconds the signal has been present.
- Used to loop back and check generator output and to qualify camera/strobe-type periodic inputs on the 27 MHz board clock.

---
 rtl/square_signal_meter.sv | 151 +++++++++++++++
 tb/tb_square_signal_meter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/square_signal_meter.sv
// Square-wave input meter: per-edge period and high time, 1 s gated frequency count,
// lock state with timeout and a seconds-locked counter.
module square_signal_meter #(
  parameter int unsigned clock_freq = 27000000,
  parameter int unsigned min_freq   = 1,
  parameter int unsigned cnt_width  = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig_in,
  output logic [cnt_width-1:0] period_cycles,
  output logic [cnt_width-1:0] high_cycles,
  output logic                 period_valid,
  output logic [15:0]          freq_hz,
  output logic                 freq_valid,
  output logic                 active,
  output logic [8:0]           seconds_active
);

  localparam int unsigned TimeoutCycles = clock_freq / min_freq;
  localparam int unsigned GateW         = (clock_freq > 1) ? $clog2(clock_freq) : 1;

  localparam logic [cnt_width-1:0] TimeoutLast = cnt_width'(TimeoutCycles - 1);
  localparam logic [GateW-1:0]     GateLast    = GateW'(clock_freq - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StLocked} state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, hist_q;
  logic [cnt_width-1:0] pcnt_q, pcnt_d;
  logic [cnt_width-1:0] hcnt_q, hcnt_d;
  logic [cnt_width-1:0] period_q, period_d;
  logic [cnt_width-1:0] high_q, high_d;
  logic                 pvalid_q, pvalid_d;
  logic [GateW-1:0]     gcnt_q, gcnt_d;
  logic [15:0]          ecnt_q, ecnt_d;
  logic [15:0]          freq_q, freq_d;
  logic                 fvalid_q, fvalid_d;
  logic [8:0]           sec_q, sec_d;

  logic                 rise, fall, timeout, wrap;
  logic [cnt_width-1:0] pcnt_inc, hcnt_inc;

  assign rise     = sync2_q & ~hist_q;
  assign fall     = ~sync2_q & hist_q;
  assign pcnt_inc = (&pcnt_q) ? pcnt_q : pcnt_q + cnt_width'(1);
  assign hcnt_inc = (&hcnt_q) ? hcnt_q : hcnt_q + cnt_width'(1);
  // A rise in the same cycle always beats the timeout.
  assign timeout  = (pcnt_q == TimeoutLast) & ~rise;
  assign wrap     = (gcnt_q == GateLast);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    pvalid_d = 1'b0;
    freq_d   = freq_q;
    fvalid_d = 1'b0;
    sec_d    = sec_q;
    pcnt_d   = rise ? '0 : pcnt_inc;
    hcnt_d   = rise ? '0 : hcnt_inc;
    gcnt_d   = wrap ? '0 : gcnt_q + GateW'(1);
    ecnt_d   = ecnt_q;

    if (fall && (state_q != StIdle)) begin
      high_d = hcnt_inc;
    end

    // A rise on the wrap cycle belongs to the window that is closing.
    if (wrap) begin
      fvalid_d = 1'b1;
      ecnt_d   = '0;
      freq_d   = (rise && (ecnt_q != 16'hFFFF)) ? ecnt_q + 16'd1 : ecnt_q;
      if ((state_q == StLocked) && !timeout && (sec_q != 9'h1FF)) begin
        sec_d = sec_q + 9'd1;
      end
    end else if (rise && (ecnt_q != 16'hFFFF)) begin
      ecnt_d = ecnt_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (rise) state_d = StArmed;
      end
      StArmed: begin
        if (rise) begin
          state_d  = StLocked;
          period_d = pcnt_inc;
          pvalid_d = 1'b1;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StLocked: begin
        if (rise) begin
          period_d = pcnt_inc;
          pvalid_d = 1'b1;
        end else if (timeout) begin
          state_d  = StIdle;
          period_d = '0;
          high_d   = '0;
          sec_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      hist_q   <= 1'b0;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      pvalid_q <= 1'b0;
      gcnt_q   <= '0;
      ecnt_q   <= '0;
      freq_q   <= '0;
      fvalid_q <= 1'b0;
      sec_q    <= '0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sig_in;
      sync2_q  <= sync1_q;
      hist_q   <= sync2_q;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      pvalid_q <= pvalid_d;
      gcnt_q   <= gcnt_d;
      ecnt_q   <= ecnt_d;
      freq_q   <= freq_d;
      fvalid_q <= fvalid_d;
      sec_q    <= sec_d;
    end
  end

  assign period_cycles  = period_q;
  assign high_cycles    = high_q;
  assign period_valid   = pvalid_q;
  assign freq_hz        = freq_q;
  assign freq_valid     = fvalid_q;
  assign active         = (state_q == StLocked);
  assign seconds_active = sec_q;

endmodule

// File: tb/tb_square_signal_meter.sv
// Scoreboard bench for square_signal_meter: expected period/frequency results are queued
// as stimulus is driven and a negedge monitor pops them on each valid pulse.
module tb_square_signal_meter;

  localparam int CW = 25;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sig_in = 1'b0;
  logic [CW-1:0] period_cycles, high_cycles;
  logic          period_valid, freq_valid, active;
  logic [15:0]   freq_hz;
  logic [8:0]    seconds_active;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit never_lock = 1'b0;

  typedef struct {
    int unsigned a;
    int unsigned b;
  } pair_t;

  pair_t exp_period[$];
  pair_t exp_freq[$];

  square_signal_meter #(
    .clock_freq(1000),
    .min_freq  (10),
    .cnt_width (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sig_in        (sig_in),
    .period_cycles (period_cycles),
    .high_cycles   (high_cycles),
    .period_valid  (period_valid),
    .freq_hz       (freq_hz),
    .freq_valid    (freq_valid),
    .active        (active),
    .seconds_active(seconds_active)
  );

  always #5 clk = ~clk;

  // cyc == n just after the n-th rising edge since reset release
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    pair_t e;
    if (!rst) begin
      if (period_valid) begin
        if (exp_period.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected period_valid: got period %0d, expected no pulse (cyc %0d)",
                   period_cycles, cyc);
        end else begin
          e = exp_period.pop_front();
          chk("period_cycles", period_cycles, e.a);
          chk("high_cycles", high_cycles, e.b);
        end
      end
      if (freq_valid) begin
        if (exp_freq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected freq_valid: got freq %0d, expected no pulse (cyc %0d)",
                   freq_hz, cyc);
        end else begin
          e = exp_freq.pop_front();
          chk("freq_hz", freq_hz, e.a);
          chk("seconds_active", seconds_active, e.b);
        end
      end
      if (never_lock) chk("active held low", active, 0);
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int start, input int high);
    goto(start);
    sig_in = 1'b1;
    goto(start + high);
    sig_in = 1'b0;
  endtask

  // Rises driven at start+i*period are detected 3 edges later; pulses expected from rise push_from.
  task automatic square(input int start, input int high, input int period, input int count,
                        input int push_from);
    for (int i = 0; i < count; i++) begin
      goto(start + i * period);
      sig_in = 1'b1;
      if (i >= push_from) exp_period.push_back('{period, high});
      goto(start + i * period + high);
      sig_in = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " period_cycles"}, period_cycles, 0);
    chk({tag, " high_cycles"}, high_cycles, 0);
    chk({tag, " period_valid"}, period_valid, 0);
    chk({tag, " freq_hz"}, freq_hz, 0);
    chk({tag, " freq_valid"}, freq_valid, 0);
    chk({tag, " active"}, active, 0);
    chk({tag, " seconds_active"}, seconds_active, 0);
  endtask

  task automatic do_reset();
    chk("period queue drained", exp_period.size(), 0);
    chk("freq queue drained", exp_freq.size(), 0);
    exp_period.delete();
    exp_freq.delete();
    never_lock = 1'b0;
    rst = 1'b1;
    sig_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Continuous 10/10 wave, then silence: lock, gate counts, timeout clear.
    do_reset();
    exp_freq.push_back('{50, 1});
    exp_freq.push_back('{50, 2});
    exp_freq.push_back('{50, 3});
    exp_freq.push_back('{0, 0});
    square(10, 10, 20, 150, 1);
    chk("s1 active locked", active, 1);
    goto(3092);
    chk("s2 active before timeout", active, 1);
    chk("s2 seconds before timeout", seconds_active, 3);
    goto(3093);
    chk("s2 active after timeout", active, 0);
    chk("s2 period cleared", period_cycles, 0);
    chk("s2 high cleared", high_cycles, 0);
    chk("s2 seconds cleared", seconds_active, 0);
    goto(4001);

    // Rise detected exactly on the gate wrap cycle (edge 1000).
    do_reset();
    exp_freq.push_back('{2, 0});
    exp_freq.push_back('{1, 0});
    pulse(497, 5);
    pulse(997, 5);
    pulse(1497, 5);
    goto(2001);

    // Asynchronous reset mid-period while locked, then relock.
    do_reset();
    square(10, 10, 20, 6, 1);
    goto(124);
    chk("s5 active before reset", active, 1);
    chk("s5 period before reset", period_cycles, 20);
    #3;
    rst = 1'b1;
    #2;
    check_zero("async reset");
    do_reset();
    pulse(10, 10);
    exp_period.push_back('{20, 10});
    goto(30);
    sig_in = 1'b1;
    goto(32);
    chk("s5 active before 2nd rise", active, 0);
    goto(33);
    chk("s5 active after 2nd rise", active, 1);
    goto(40);
    sig_in = 1'b0;
    square(50, 10, 20, 2, 0);
    goto(120);

    // Single pulse then silence; later rises probe the exact timeout boundary.
    do_reset();
    never_lock = 1'b1;
    pulse(10, 10);
    goto(50);
    chk("s3 high after lone pulse", high_cycles, 10);
    chk("s3 period after lone pulse", period_cycles, 0);
    pulse(111, 5);
    goto(150);
    chk("s3 high kept", high_cycles, 5);
    never_lock = 1'b0;
    goto(211);
    sig_in = 1'b1;
    exp_period.push_back('{100, 5});
    goto(213);
    chk("s3 active before rise-vs-timeout", active, 0);
    goto(214);
    chk("s3 rise beats timeout", active, 1);
    goto(220);
    sig_in = 1'b0;
    goto(400);

    // Period 99: stays locked; times out 100 cycles after the last rise.
    do_reset();
    square(10, 50, 99, 8, 1);
    goto(805);
    chk("s6 active at 99 period", active, 1);
    goto(806);
    chk("s6 active after timeout", active, 0);
    chk("s6 period cleared", period_cycles, 0);
    chk("s6 high cleared", high_cycles, 0);

    // Period 150: ARMED/IDLE toggling, never locks.
    do_reset();
    never_lock = 1'b1;
    square(10, 75, 150, 4, 99);
    goto(540);
    chk("s6b high while armed", high_cycles, 75);
    chk("s6b period never loaded", period_cycles, 0);
    chk("s6b active", active, 0);
    goto(700);
    never_lock = 1'b0;

    chk("period queue drained", exp_period.size(), 0);
    chk("freq queue drained", exp_freq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
